// File: rtl/mux41_frame_serializer.sv
// Holds a 4-bit word on the 4:1 mux data inputs and steps the select lines one index per clock.
// Optional macro SERIALIZER_PARITY_EN appends an even-parity cycle and a par_bit output.
module mux41_frame_serializer #(
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       load_valid,
    output logic       load_ready,
    output logic [3:0] d_hold,
    output logic [1:0] sel,
    output logic       ser_out,
    output logic       dout_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       busy
`ifdef SERIALIZER_PARITY_EN
    ,
    output logic       par_bit
`endif
);

    // Handshake: a word moves on any rising edge where load_valid && load_ready;
    // load_valid/din are don't-care while load_ready is low.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [1:0] FIRST_SEL = MSB_FIRST ? 2'd3 : 2'd0;
    // 2'd3 is -1 modulo 4, so the same adder walks either direction.
    localparam logic [1:0] SEL_STEP  = MSB_FIRST ? 2'd3 : 2'd1;
`ifdef SERIALIZER_PARITY_EN
    localparam logic [2:0] LAST_CNT  = 3'd4;
`else
    localparam logic [2:0] LAST_CNT  = 3'd3;
`endif
    localparam logic [3:0] GAP_LOAD  = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_t     state;
    logic [2:0] bit_cnt;
    logic [3:0] gap_cnt;
    logic       last_bit;
    logic       xfer;
    logic [1:0] sel_next;

    assign last_bit   = (state == SHIFT) && (bit_cnt == LAST_CNT);
    // With no gap, the last bit cycle also accepts the next word so frames abut.
    assign load_ready = (state == IDLE) || ((GAP_CYCLES == 0) && last_bit);
    assign xfer       = load_valid && load_ready;
    assign busy       = (state != IDLE);
    assign sel_next   = sel + SEL_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            d_hold      <= '0;
            sel         <= FIRST_SEL;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            ser_out     <= 1'b0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_bit     <= 1'b0;
`endif
        end else if (xfer) begin
            state       <= SHIFT;
            d_hold      <= din;
            sel         <= FIRST_SEL;
            bit_cnt     <= '0;
            ser_out     <= din[FIRST_SEL];
            dout_valid  <= 1'b1;
            frame_start <= 1'b1;
            frame_end   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_bit     <= 1'b0;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (last_bit) begin
                        sel         <= FIRST_SEL;
                        ser_out     <= 1'b0;
                        dout_valid  <= 1'b0;
                        frame_start <= 1'b0;
                        frame_end   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
                        par_bit     <= 1'b0;
`endif
                        if (GAP_CYCLES != 0) begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state   <= IDLE;
                        end
                    end else begin
                        bit_cnt     <= bit_cnt + 3'd1;
                        frame_start <= 1'b0;
                        frame_end   <= (bit_cnt == LAST_CNT - 3'd1);
`ifdef SERIALIZER_PARITY_EN
                        // After the fourth data bit, sel parks and the parity bit goes out.
                        if (bit_cnt < 3'd3) begin
                            sel     <= sel_next;
                            ser_out <= d_hold[sel_next];
                            par_bit <= 1'b0;
                        end else begin
                            ser_out <= ^d_hold;
                            par_bit <= 1'b1;
                        end
`else
                        sel         <= sel_next;
                        ser_out     <= d_hold[sel_next];
`endif
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                IDLE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux41_frame_serializer.sv
// Bench for mux41_frame_serializer: LSB-first/no-gap instance A and MSB-first/gap-2 instance B,
// table-driven frames scored through per-instance expected queues plus corner sequences.
module tb_mux41_frame_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = PAR ? 5 : 4;

    logic       clk;
    logic       rst;
    logic [3:0] din_a, din_b;
    logic       lv_a, lv_b;
    logic       load_ready_a, load_ready_b;
    logic [3:0] d_hold_a, d_hold_b;
    logic [1:0] sel_a, sel_b;
    logic       ser_out_a, ser_out_b;
    logic       dout_valid_a, dout_valid_b;
    logic       frame_start_a, frame_start_b;
    logic       frame_end_a, frame_end_b;
    logic       busy_a, busy_b;
    logic       par_a, par_b;

    int tests = 0;
    int fails = 0;
    int valid_cnt_a = 0;
    int nrdy_b = 0;

    // entry = {d_hold, sel, ser_out, frame_start, frame_end, par_bit}
    logic [9:0] exp_q_a[$];
    logic [9:0] exp_q_b[$];

    typedef struct {
        logic [3:0] din;
        logic [3:0] seq_a;  // bits in time order for LSB-first, leftmost first
        logic [3:0] seq_b;  // bits in time order for MSB-first, leftmost first
        logic       par;
    } vec_t;
    vec_t vecs[10];

    mux41_frame_serializer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_dut_a (
        .clk(clk), .rst(rst), .din(din_a), .load_valid(lv_a), .load_ready(load_ready_a),
        .d_hold(d_hold_a), .sel(sel_a), .ser_out(ser_out_a), .dout_valid(dout_valid_a),
        .frame_start(frame_start_a), .frame_end(frame_end_a), .busy(busy_a)
`ifdef SERIALIZER_PARITY_EN
        , .par_bit(par_a)
`endif
    );

    mux41_frame_serializer #(.MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_b), .load_valid(lv_b), .load_ready(load_ready_b),
        .d_hold(d_hold_b), .sel(sel_b), .ser_out(ser_out_b), .dout_valid(dout_valid_b),
        .frame_start(frame_start_b), .frame_end(frame_end_b), .busy(busy_b)
`ifdef SERIALIZER_PARITY_EN
        , .par_bit(par_b)
`endif
    );

`ifndef SERIALIZER_PARITY_EN
    assign par_a = 1'b0;
    assign par_b = 1'b0;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic push_a(input logic [3:0] w, input logic [3:0] seq, input logic p);
        for (int i = 0; i < 4; i++)
            exp_q_a.push_back({w, 2'(i), seq[3-i], 1'(i == 0), 1'((i == 3) && !PAR), 1'b0});
        if (PAR) exp_q_a.push_back({w, 2'd3, p, 1'b0, 1'b1, 1'b1});
    endtask

    task automatic push_b(input logic [3:0] w, input logic [3:0] seq, input logic p);
        for (int i = 0; i < 4; i++)
            exp_q_b.push_back({w, 2'(3 - i), seq[3-i], 1'(i == 0), 1'((i == 3) && !PAR), 1'b0});
        if (PAR) exp_q_b.push_back({w, 2'd0, p, 1'b0, 1'b1, 1'b1});
    endtask

    // driver: present a word, wait for load_ready, record expected frame at the transfer
    task automatic send(input bit to_b, input logic [3:0] w, input logic [3:0] seq,
                        input logic p, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        if (to_b) begin din_b = w; lv_b = 1'b1; end
        else      begin din_a = w; lv_a = 1'b1; end
        while (!(to_b ? load_ready_b : load_ready_a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL load_timeout inst=%0d actual=%0d cycles required=<100", to_b, n);
        end else if (to_b) begin
            push_b(w, seq, p);
        end else begin
            push_a(w, seq, p);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            if (to_b) lv_b = 1'b0;
            else      lv_a = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q_a.size() != 0 || exp_q_b.size() != 0 || busy_a || busy_b) && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        tests++;
        if (n >= 300) begin
            fails++;
            $display("FAIL idle_timeout actual=%0d cycles required=<300", n);
        end
    endtask

    // scoreboard: pop and compare every valid bit, check quiet outputs otherwise
    always @(negedge clk) begin
        if (!rst) begin
            if (dout_valid_a) begin
                valid_cnt_a++;
                if (exp_q_a.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_a actual=%b required=none",
                             {d_hold_a, sel_a, ser_out_a, frame_start_a, frame_end_a, par_a});
                end else begin
                    chk("frame_a", {d_hold_a, sel_a, ser_out_a, frame_start_a, frame_end_a, par_a},
                        exp_q_a.pop_front());
                end
            end else begin
                chk("quiet_a", 10'({ser_out_a, frame_start_a, frame_end_a, par_a}), 10'd0);
            end
            if (dout_valid_b) begin
                if (exp_q_b.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_b actual=%b required=none",
                             {d_hold_b, sel_b, ser_out_b, frame_start_b, frame_end_b, par_b});
                end else begin
                    chk("frame_b", {d_hold_b, sel_b, ser_out_b, frame_start_b, frame_end_b, par_b},
                        exp_q_b.pop_front());
                end
            end else begin
                chk("quiet_b", 10'({ser_out_b, frame_start_b, frame_end_b, par_b}), 10'd0);
                if (!load_ready_b) nrdy_b++;
            end
        end
    end

    initial begin
        int v0;
        int g0;
        logic [3:0] w;

        vecs[0] = '{4'b1001, 4'b1001, 4'b1001, 1'b0};
        vecs[1] = '{4'b1100, 4'b0011, 4'b1100, 1'b0};
        vecs[2] = '{4'b1010, 4'b0101, 4'b1010, 1'b0};
        vecs[3] = '{4'b0101, 4'b1010, 4'b0101, 1'b0};
        vecs[4] = '{4'b0111, 4'b1110, 4'b0111, 1'b1};
        vecs[5] = '{4'b0011, 4'b1100, 4'b0011, 1'b0};
        vecs[6] = '{4'b1111, 4'b1111, 4'b1111, 1'b0};
        vecs[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[8] = '{4'b1000, 4'b0001, 4'b1000, 1'b1};
        vecs[9] = '{4'b1011, 4'b1101, 4'b1011, 1'b1};

        rst = 1'b0; din_a = '0; din_b = '0; lv_a = 1'b0; lv_b = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_load_ready_a", 10'(load_ready_a), 10'd1);
        chk("rst_busy_a", 10'(busy_a), 10'd0);
        chk("rst_sel_b", 10'(sel_b), 10'd3);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_outs_a", 10'({d_hold_a, sel_a, ser_out_a, dout_valid_a, frame_start_a, frame_end_a}), 10'd0);
        chk("idle_outs_b", 10'({d_hold_b, sel_b, ser_out_b, dout_valid_b, frame_start_b, frame_end_b}),
            10'({4'd0, 2'd3, 4'd0}));
        chk("idle_ready", 10'({load_ready_a, load_ready_b, busy_a, busy_b}), 10'b1100);

        // table-driven frames on both instances
        for (int i = 0; i < 10; i++) begin
            send(1'b0, vecs[i].din, vecs[i].seq_a, vecs[i].par, 1'b0);
            send(1'b1, vecs[i].din, vecs[i].seq_b, vecs[i].par, 1'b0);
        end
        wait_idle();

        // random words through the same model
        for (int i = 0; i < 6; i++) begin
            w = 4'($urandom_range(0, 15));
            send(1'b0, w, rev4(w), ^w, 1'b0);
            send(1'b1, w, w, ^w, 1'b0);
        end
        wait_idle();

        // back-to-back on A: two frames with no bubble
        send(1'b0, 4'hA, 4'b0101, 1'b0, 1'b1);
        v0 = valid_cnt_a;
        send(1'b0, 4'h5, 4'b1010, 1'b0, 1'b0);
        repeat (FL) @(negedge clk);
        #1;
        chk("b2b_valid_cycles", 10'(valid_cnt_a - v0), 10'(2 * FL));
        wait_idle();

        // gap on B: load_ready low for exactly two idle cycles between frames
        g0 = nrdy_b;
        send(1'b1, 4'b1100, 4'b1100, 1'b0, 1'b1);
        send(1'b1, 4'b0110, 4'b0110, 1'b0, 1'b0);
        chk("gap_ready_low", 10'(nrdy_b - g0), 10'd2);
        wait_idle();

        // load_valid during SHIFT (not the last bit) must be ignored
        send(1'b0, 4'b0011, 4'b1100, 1'b0, 1'b0);
        din_a = 4'b1111;
        lv_a = 1'b1;
        repeat (2) @(negedge clk);
        lv_a = 1'b0;
        wait_idle();
        chk("ignored_load_hold", 10'(d_hold_a), 10'b0011);

        // reset in the middle of bit 2 abandons the frame
        send(1'b0, 4'b0110, 4'b0110, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_outs", 10'({dout_valid_a, frame_end_a, busy_a, load_ready_a}), 10'b0001);
        chk("abort_state", 10'({d_hold_a, sel_a}), 10'd0);
        exp_q_a.delete();
        @(negedge clk);
        rst = 1'b0;
        send(1'b0, 4'b0101, 4'b1010, 1'b0, 1'b0);
        wait_idle();

        chk("end_sel", 10'({sel_a, sel_b}), 10'b0011);
        chk("end_busy", 10'({busy_a, busy_b}), 10'd0);
        chk("end_queues", 10'(exp_q_a.size() + exp_q_b.size()), 10'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
